// File: rtl/vga_framebuffer_scanout_if.sv
// Pixel-write stream from the game renderer into the framebuffer.
//   x, y, colour, plot : write coordinate, {R,G,B} data and strobe (master -> slave)
//   busy               : framebuffer clear in progress, writes dropped (slave -> master)
interface vga_framebuffer_scanout_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (output x, y, colour, plot, input busy);
  modport slave  (input x, y, colour, plot, output busy);
endinterface

// File: rtl/vga_framebuffer_scanout.sv
// 160x120x3 framebuffer with a post-reset clear and 640x480@60 VGA scan-out
// using 4x pixel replication.
//   clk, reset  : 50 MHz clock, synchronous active-high reset
//   wr          : pixel-write stream (slave side), busy while clearing
//   VGA_*       : pixel clock, syncs, blank, and 10-bit DAC channels
module vga_framebuffer_scanout #(
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter int unsigned SCALE_LOG2   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  vga_framebuffer_scanout_if.slave        wr,
  output logic                            VGA_CLK,
  output logic                            VGA_HS,
  output logic                            VGA_VS,
  output logic                            VGA_BLANK_N,
  output logic                            VGA_SYNC_N,
  output logic [9:0]                      VGA_R,
  output logic [9:0]                      VGA_G,
  output logic [9:0]                      VGA_B
);

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_VIS    = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 751;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_VIS    = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 491;
  localparam int unsigned V_TOTAL  = 525;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // y*160 + x as shift-and-add
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [6:0] row, input logic [7:0] col);
    return ADDR_W'({row, 7'd0}) + ADDR_W'({row, 5'd0}) + ADDR_W'(col);
  endfunction

  // Clear FSM and write port
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [2:0]          wdata_c;

  // Scan counters, phase and output pipeline
  logic                ph_q, ph_d;
  logic                vga_clk_q, vga_clk_d;
  logic [CNT_W-1:0]    hcount_q, hcount_d;
  logic [CNT_W-1:0]    vcount_q, vcount_d;
  logic                s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_blank_n_q, s1_blank_n_d;
  logic [2:0]          s1_rgb_q, s1_rgb_d;
  logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                hs_c, vs_c, vis_c;
  logic [ADDR_W-1:0]   raddr_c;
  logic [2:0]          rd_data_q;

  logic [2:0]          mem [FB_DEPTH];

  // Clear sequencing and pixel-write acceptance
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we_c       = 1'b0;
    waddr_c    = clr_addr_q;
    wdata_c    = CLEAR_COLOUR;
    case (state_q)
      ST_CLEAR: begin
        we_c = 1'b1;
        if (clr_addr_q == ADDR_W'(FB_DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        // Out-of-range coordinates are dropped rather than wrapped
        if (wr.plot && (wr.x < 8'(FB_W)) && (wr.y < 7'(FB_H))) begin
          we_c    = 1'b1;
          waddr_c = pix_addr(wr.y, wr.x);
          wdata_c = wr.colour;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Scan timing: counters advance on ph=1 cycles; every stage shares that enable
  always_comb begin
    ph_d         = ~ph_q;
    vga_clk_d    = ~ph_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    s1_hs_d      = s1_hs_q;
    s1_vs_d      = s1_vs_q;
    s1_blank_n_d = s1_blank_n_q;
    s1_rgb_d     = s1_rgb_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    blank_n_d    = blank_n_q;
    rgb_d        = rgb_q;

    hs_c    = !((hcount_q >= CNT_W'(H_SYNC_S)) && (hcount_q <= CNT_W'(H_SYNC_E)));
    vs_c    = !((vcount_q >= CNT_W'(V_SYNC_S)) && (vcount_q <= CNT_W'(V_SYNC_E)));
    vis_c   = (hcount_q < CNT_W'(H_VIS)) && (vcount_q < CNT_W'(V_VIS));
    raddr_c = pix_addr(7'(vcount_q >> SCALE_LOG2), 8'(hcount_q >> SCALE_LOG2));

    if (ph_q) begin
      if (hcount_q == CNT_W'(H_TOTAL - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      // Stage 1: RAM data read on the previous (ph=0) edge joins its sync/blank
      s1_hs_d      = hs_c;
      s1_vs_d      = vs_c;
      s1_blank_n_d = vis_c;
      s1_rgb_d     = rd_data_q;
      // Stage 2: output registers, colour forced black outside the visible area
      hs_d         = s1_hs_q;
      vs_d         = s1_vs_q;
      blank_n_d    = s1_blank_n_q;
      rgb_d        = s1_blank_n_q ? s1_rgb_q : 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      ph_q         <= 1'b0;
      vga_clk_q    <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      s1_hs_q      <= 1'b1;
      s1_vs_q      <= 1'b1;
      s1_blank_n_q <= 1'b0;
      s1_rgb_q     <= 3'b000;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_n_q    <= 1'b0;
      rgb_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      ph_q         <= ph_d;
      vga_clk_q    <= vga_clk_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      s1_blank_n_q <= s1_blank_n_d;
      s1_rgb_q     <= s1_rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_n_q    <= blank_n_d;
      rgb_q        <= rgb_d;
    end
  end

  // Framebuffer: read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (we_c && !reset) mem[waddr_c] <= wdata_c;
    if (vis_c) rd_data_q <= mem[raddr_c];
  end

  assign wr.busy     = (state_q == ST_CLEAR);
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = {10{rgb_q[2]}};
  assign VGA_G       = {10{rgb_q[1]}};
  assign VGA_B       = {10{rgb_q[0]}};

endmodule
